// File: rtl/cordic_pkg.sv
// Shared constants for the iterative vectoring CORDIC: widths, the arctangent
// table, the gain-compensation constant and the FSM state encoding.
package cordic_pkg;

  localparam int INTEGER_WIDTH    = 2;
  localparam int FRACTIONAL_WIDTH = 20;
  localparam int DATA_WIDTH       = INTEGER_WIDTH + FRACTIONAL_WIDTH;
  // One extra integer bit so the angle can reach +/-pi.
  localparam int ANGLE_WIDTH      = DATA_WIDTH + 1;
  localparam int ITERATIONS       = 16;
  localparam int ITER_BITS        = 4;

  localparam logic [ITER_BITS-1:0] ITER_LAST = ITER_BITS'(ITERATIONS - 1);

  // pi/2 with 20 fractional bits.
  localparam logic signed [ANGLE_WIDTH-1:0] PI_HALF = 23'sh1921FB;
  // 1/K for the 16-stage CORDIC gain (K ~= 1.6468), 20 fractional bits.
  localparam logic signed [DATA_WIDTH-1:0]  K_INV   = 22'sh09B74E;

  // FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PRE   = 2'd1;
  localparam state_t ST_ITER  = 2'd2;
  localparam state_t ST_SCALE = 2'd3;

  // atan(2^-idx) with 20 fractional bits, truncated toward zero.
  function automatic logic signed [ANGLE_WIDTH-1:0] atan_lut(input logic [ITER_BITS-1:0] idx);
    logic [DATA_WIDTH-1:0] v;
    case (idx)
      4'd0:    v = 22'h0C90FD;
      4'd1:    v = 22'h076B19;
      4'd2:    v = 22'h03EB6E;
      4'd3:    v = 22'h01FD5B;
      4'd4:    v = 22'h00FFAA;
      4'd5:    v = 22'h007FF5;
      4'd6:    v = 22'h003FFE;
      4'd7:    v = 22'h001FFF;
      4'd8:    v = 22'h000FFF;
      4'd9:    v = 22'h0007FF;
      4'd10:   v = 22'h0003FF;
      4'd11:   v = 22'h0001FF;
      4'd12:   v = 22'h0000FF;
      4'd13:   v = 22'h00007F;
      4'd14:   v = 22'h00003F;
      default: v = 22'h00001F;
    endcase
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/cordic_vector_stage.sv
// One combinational vectoring micro-rotation: drives y toward zero and
// accumulates the rotated angle in z. Both updates use the incoming x and y.
module cordic_vector_stage
  import cordic_pkg::*;
(
  input  logic signed [DATA_WIDTH-1:0]  x_i,
  input  logic signed [DATA_WIDTH-1:0]  y_i,
  input  logic signed [ANGLE_WIDTH-1:0] z_i,
  input  logic        [ITER_BITS-1:0]   shift_i,
  input  logic signed [ANGLE_WIDTH-1:0] atan_i,
  output logic signed [DATA_WIDTH-1:0]  x_o,
  output logic signed [DATA_WIDTH-1:0]  y_o,
  output logic signed [ANGLE_WIDTH-1:0] z_o
);

  logic signed [DATA_WIDTH-1:0] x_sh;
  logic signed [DATA_WIDTH-1:0] y_sh;

  assign x_sh = x_i >>> shift_i;
  assign y_sh = y_i >>> shift_i;

  // Rotate clockwise when y is non-negative, counter-clockwise otherwise.
  always_comb begin
    if (!y_i[DATA_WIDTH-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_i;
    end
  end

endmodule

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring CORDIC: returns atan2(y,x) and the gain-compensated
// length of (x,y), reusing one micro-rotation stage for 16 cycles.
// Handshake: start (sampled in IDLE) -> busy ... done pulse, valid held.
module cordic_vectoring_iter
  import cordic_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_en,
  input  logic                          start,
  input  logic signed [DATA_WIDTH-1:0]  x_in,
  input  logic signed [DATA_WIDTH-1:0]  y_in,
  output logic signed [ANGLE_WIDTH-1:0] angle,
  output logic        [DATA_WIDTH-1:0]  magnitude,
  output logic                          busy,
  output logic                          done,
  output logic                          valid
);

  state_t                         state_q, state_d;
  logic        [ITER_BITS-1:0]    cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0]   x_q, x_d;
  logic signed [DATA_WIDTH-1:0]   y_q, y_d;
  logic signed [ANGLE_WIDTH-1:0]  z_q, z_d;
  logic                           zero_q, zero_d;
  logic signed [ANGLE_WIDTH-1:0]  angle_q, angle_d;
  logic        [DATA_WIDTH-1:0]   mag_q, mag_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           valid_q, valid_d;

  logic signed [DATA_WIDTH-1:0]   x_rot, y_rot;
  logic signed [ANGLE_WIDTH-1:0]  z_rot;
  logic signed [ANGLE_WIDTH-1:0]  atan_cur;
  logic signed [2*DATA_WIDTH-1:0] scaled_prod;
  logic                           unused_prod_bits;

  assign atan_cur = atan_lut(cnt_q);

  cordic_vector_stage u_stage (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (cnt_q),
    .atan_i  (atan_cur),
    .x_o     (x_rot),
    .y_o     (y_rot),
    .z_o     (z_rot)
  );

  // Gain compensation; x stays below 2 so bits above the output width are sign copies.
  assign scaled_prod      = x_q * K_INV;
  assign unused_prod_bits = ^{scaled_prod[2*DATA_WIDTH-1:FRACTIONAL_WIDTH+DATA_WIDTH],
                              scaled_prod[FRACTIONAL_WIDTH-1:0]};

  // State and datapath registers; clk_en low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: IDLE -> PRE -> ITER x16 -> SCALE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_PRE;
      ST_PRE:   state_d = ST_ITER;
      ST_ITER:  if (cnt_q == ITER_LAST) state_d = ST_SCALE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and output updates for each state.
  always_comb begin
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = '0;
          cnt_d   = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      ST_PRE: begin
        // Fold the left half-plane onto the right so the iterations converge.
        cnt_d = '0;
        if (x_q[DATA_WIDTH-1]) begin
          if (!y_q[DATA_WIDTH-1]) begin
            x_d = y_q;
            y_d = -x_q;
            z_d = PI_HALF;
          end else begin
            x_d = -y_q;
            y_d = x_q;
            z_d = -PI_HALF;
          end
        end
      end
      ST_ITER: begin
        x_d   = x_rot;
        y_d   = y_rot;
        z_d   = z_rot;
        cnt_d = cnt_q + 4'd1;
      end
      default: begin
        // The all-zero vector has no defined angle; report a clean zero result.
        if (zero_q) begin
          angle_d = '0;
          mag_d   = '0;
        end else begin
          angle_d = z_q;
          mag_d   = scaled_prod[FRACTIONAL_WIDTH +: DATA_WIDTH];
        end
        done_d  = 1'b1;
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign angle     = angle_q;
  assign magnitude = mag_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Directed bench for the iterative vectoring CORDIC plus a random sweep
// against a real-valued atan2/length model.
module tb_cordic_vectoring_iter;
  import cordic_pkg::*;

  localparam real SCALE_F = 1048576.0;
  localparam real PI_R    = 3.14159265358979323846;
  localparam real MAG_TOL = 32.0;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          clk_en;
  logic                          start;
  logic signed [DATA_WIDTH-1:0]  x_in;
  logic signed [DATA_WIDTH-1:0]  y_in;
  logic signed [ANGLE_WIDTH-1:0] angle;
  logic        [DATA_WIDTH-1:0]  magnitude;
  logic                          busy;
  logic                          done;
  logic                          valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cordic_vectoring_iter dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .angle     (angle),
    .magnitude (magnitude),
    .busy      (busy),
    .done      (done),
    .valid     (valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Tolerance check; angle differences are taken modulo 2*pi.
  task automatic check_near(input string tag, input longint got, input real exp,
                            input real tol, input bit is_angle);
    real d;
    bit  ok;
    d = real'(got) - exp;
    if (is_angle) begin
      if (d > PI_R * SCALE_F)  d = d - 2.0 * PI_R * SCALE_F;
      if (d < -PI_R * SCALE_F) d = d + 2.0 * PI_R * SCALE_F;
    end
    ok = (d <= tol) && (d >= -tol);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0.1f (tol %0.1f)", tag, got, exp, tol);
    end
  endtask

  // Angle error budget: final residual atan(2^-15) ~ 32 LSB, truncated table
  // ~14 LSB, plus y truncation referred through the (gain-scaled) vector length.
  function automatic real angle_tol(input real mag_lsb);
    real m;
    m = (mag_lsb < 1.0) ? 1.0 : mag_lsb;
    return 48.0 + 24.0 * SCALE_F / (1.6468 * m);
  endfunction

  task automatic start_op(input int xv, input int yv);
    x_in  = DATA_WIDTH'(xv);
    y_in  = DATA_WIDTH'(yv);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts enabled edges from the start edge until done is seen, bounded.
  task automatic wait_done(output int lat, input int budget);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (done !== 1'b1 && lat < budget);
  endtask

  task automatic run_vec(input string tag, input int xv, input int yv,
                         input real exp_ang, input real exp_mag);
    int lat;
    start_op(xv, yv);
    check_eq({tag, "_busy"}, longint'(busy), 1);
    check_eq({tag, "_valid_clr"}, longint'(valid), 0);
    wait_done(lat, 40);
    check_eq({tag, "_lat"}, lat, 18);
    check_near({tag, "_ang"}, longint'(angle), exp_ang, angle_tol(exp_mag), 1'b1);
    check_near({tag, "_mag"}, longint'(magnitude), exp_mag, MAG_TOL, 1'b0);
    check_eq({tag, "_valid"}, longint'(valid), 1);
    $display("vec %s x=%0d y=%0d angle=%0d mag=%0d lat=%0d", tag, xv, yv,
             longint'(angle), longint'(magnitude), lat);
  endtask

  initial begin
    int lat;
    int n_done;
    int first;
    longint first_ang;
    int xv;
    int yv;
    real ea;
    real em;

    rst    = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    x_in   = '0;
    y_in   = '0;
    tick();
    tick();
    check_eq("rst_angle", longint'(angle), 0);
    check_eq("rst_mag",   longint'(magnitude), 0);
    check_eq("rst_busy",  longint'(busy), 0);
    check_eq("rst_done",  longint'(done), 0);
    check_eq("rst_valid", longint'(valid), 0);
    rst = 1'b0;
    tick();
    check_eq("idle_done", longint'(done), 0);
    $display("reset released");

    // Basic vectors, each issued in the done cycle of the previous one.
    run_vec("x_half", 524288, 0, 0.0, 524288.0);
    tick();
    check_eq("done_pulse", longint'(done), 0);
    check_eq("valid_hold", longint'(valid), 1);

    run_vec("y_half", 0, 524288, 1647099.0, 524288.0);

    // done stays high while clk_en is low.
    clk_en = 1'b0;
    tick(); tick(); tick();
    check_eq("done_frozen", longint'(done), 1);
    clk_en = 1'b1;
    tick();
    check_eq("done_release", longint'(done), 0);

    run_vec("neg_x", -524288, 0, 3294198.0, 524288.0);
    check_eq("neg_x_pos_pi", longint'(angle > 0), 1);
    run_vec("diag", 524288, 524288, 823549.66, 741455.2);
    run_vec("diag_neg", 262144, -262144, -823549.66, 370727.6);
    run_vec("zero", 0, 0, 0.0, 0.0);
    check_eq("zero_ang_exact", longint'(angle), 0);
    check_eq("zero_mag_exact", longint'(magnitude), 0);

    // Second start while busy is ignored: exactly one done, first result.
    start_op(524288, 524288);
    tick(); tick(); tick(); tick();
    start_op(-524288, 0);
    n_done = 0;
    first = 0;
    first_ang = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done === 1'b1) begin
        n_done++;
        if (first == 0) begin
          first = c + 6;
          first_ang = longint'(angle);
        end
      end
    end
    check_eq("busy_ign_count", n_done, 1);
    check_eq("busy_ign_lat", first, 18);
    check_near("busy_ign_ang", first_ang, 823549.66, angle_tol(741455.2), 1'b1);
    $display("busy-ignore dones=%0d lat=%0d", n_done, first);

    // Reset after iteration 7 discards the operation.
    start_op(524288, 524288);
    for (int c = 0; c < 9; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_angle", longint'(angle), 0);
    check_eq("midrst_mag",   longint'(magnitude), 0);
    check_eq("midrst_busy",  longint'(busy), 0);
    check_eq("midrst_done",  longint'(done), 0);
    check_eq("midrst_valid", longint'(valid), 0);
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    check_eq("midrst_no_done", n_done, 0);
    $display("mid-op reset dones=%0d", n_done);

    // clk_en low for 5 cycles mid-ITER delays done by exactly 5.
    start_op(262144, -262144);
    for (int c = 0; c < 6; c++) tick();
    clk_en = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check_eq("stall_busy", longint'(busy), 1);
    check_eq("stall_done", longint'(done), 0);
    clk_en = 1'b1;
    wait_done(lat, 40);
    check_eq("stall_lat", 11 + lat, 23);
    check_near("stall_ang", longint'(angle), -823549.66, angle_tol(370727.6), 1'b1);
    check_near("stall_mag", longint'(magnitude), 370727.6, MAG_TOL, 1'b0);
    $display("stall total latency=%0d", 11 + lat);

    // Random sweep against a real atan2/length model.
    for (int n = 0; n < 1000; n++) begin
      xv = int'($urandom_range(0, 1048576)) - 524288;
      yv = int'($urandom_range(0, 1048576)) - 524288;
      start_op(xv, yv);
      wait_done(lat, 40);
      em = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
      ea = (xv == 0 && yv == 0) ? 0.0 : $atan2(real'(yv), real'(xv)) * SCALE_F;
      check_eq("rnd_lat", lat, 18);
      check_near("rnd_ang", longint'(angle), ea, angle_tol(em), 1'b1);
      check_near("rnd_mag", longint'(magnitude), em, MAG_TOL, 1'b0);
      $display("rnd %0d x=%0d y=%0d angle=%0d mag=%0d", n, xv, yv,
               longint'(angle), longint'(magnitude));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
